// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: sequential PC fetch from a combinational instruction memory
// into a small in-order prefetch buffer, with redirect, halt-at-end and misalignment fault.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 112,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_pc,
  output logic                     fault,
  output logic                     halted,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned      PtrW   = $clog2(DEPTH);
  localparam logic [31:0]      LastPc = 32'(IMEM_BYTES - 4);
  localparam logic [PtrW:0]    Full   = (PtrW + 1)'(DEPTH);

  typedef enum logic [1:0] {StRun, StHalt, StFault} state_e;

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]     count_q, count_d;
  logic [31:0]       instr_mem_q [DEPTH];
  logic [31:0]       pc_mem_q    [DEPTH];
  logic              push;
  logic              pop;
  logic              flush;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    pop     = out_valid && out_ready;
    flush   = 1'b0;

    if (redirect_valid) begin
      // Redirect wins over everything: drop buffered work and any pop this cycle.
      flush   = 1'b1;
      pop     = 1'b0;
      pc_d    = redirect_pc;
      state_d = (redirect_pc[1:0] != 2'b00) ? StFault : StRun;
    end else if (state_q == StRun) begin
      if (pc_q > LastPc) begin
        state_d = StHalt;
      end else if ((count_q < Full) || pop) begin
        push = 1'b1;
        pc_d = pc_q + 32'd4;
      end
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + (PtrW + 1)'(1);
      end else if (pop && !push) begin
        count_d = count_q - (PtrW + 1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StRun;
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: outputs are gated by out_valid.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      instr_mem_q[wr_ptr_q] <= imem_rdata;
      pc_mem_q[wr_ptr_q]    <= pc_q;
    end
  end

  assign imem_addr = pc_q;
  assign count     = count_q;
  assign out_valid = (count_q != '0);
  assign out_instr = out_valid ? instr_mem_q[rd_ptr_q] : '0;
  assign out_pc    = out_valid ? pc_mem_q[rd_ptr_q] : '0;
  assign fault     = (state_q == StFault);
  assign halted    = (state_q == StHalt);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed table-driven bench for instr_fetch_unit, plus a free-run sequence to the
// end of instruction memory and back.
module tb_instr_fetch_unit;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;
  logic        halted;
  logic [1:0]  count;

  int n_vec;
  int n_err;

  localparam logic [31:0] W0 = 32'h00c2_8283;
  localparam logic [31:0] W1 = 32'h8001_00b3;

  instr_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_BYTES(112),
    .DEPTH     (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .fault         (fault),
    .halted        (halted),
    .count         (count)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (a == 32'd0) return W0;
    if (a == 32'd4) return W1;
    return 32'h1300_0000 + a;
  endfunction

  assign imem_rdata = word_at(imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [1:0]  e_count;
    logic [31:0] e_addr;
    logic        e_fault;
    logic        e_halted;
  } vec_t;

  vec_t vecs [21];

  task automatic step(input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy);
    reset          = rst;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //         rst  rv    rpc     rdy   valid pc      instr              cnt   addr    flt   hlt
    vecs[0]  = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  32'h0,             2'd0, 32'h0,  1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 32'h40, 1'b1, 1'b0, 32'h0,  32'h0,             2'd0, 32'h0,  1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h0,  W0,                2'd1, 32'h4,  1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h4,  W1,                2'd1, 32'h8,  1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h8,  32'h1300_0008,     2'd1, 32'hc,  1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,             2'd0, 32'h0,  1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h0,  W0,                2'd1, 32'h4,  1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h0,  W0,                2'd2, 32'h8,  1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h0,  W0,                2'd2, 32'h8,  1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h0,  W0,                2'd2, 32'h8,  1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h0,  W0,                2'd2, 32'h8,  1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h4,  W1,                2'd2, 32'hc,  1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 32'd80, 1'b1, 1'b0, 32'h0,  32'h0,             2'd0, 32'd80, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'd80, 32'h1300_0050,     2'd1, 32'd84, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 32'h52, 1'b0, 1'b0, 32'h0,  32'h0,             2'd0, 32'h52, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,             2'd0, 32'h52, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 32'h50, 1'b0, 1'b0, 32'h0,  32'h0,             2'd0, 32'h50, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h50, 32'h1300_0050,     2'd1, 32'h54, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h50, 32'h1300_0050,     2'd2, 32'h58, 1'b0, 1'b0};
    vecs[19] = '{1'b1, 1'b1, 32'h40, 1'b1, 1'b0, 32'h0,  32'h0,             2'd0, 32'h0,  1'b0, 1'b0};
    vecs[20] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h0,  W0,                2'd1, 32'h4,  1'b0, 1'b0};

    n_vec          = 0;
    n_err          = 0;
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 21; i++) begin
      step(vecs[i].rst, vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
      check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
      check($sformatf("v%0d out_pc", i),    out_pc,         vecs[i].e_pc);
      check($sformatf("v%0d out_instr", i), out_instr,      vecs[i].e_instr);
      check($sformatf("v%0d count", i),     32'(count),     32'(vecs[i].e_count));
      check($sformatf("v%0d imem_addr", i), imem_addr,      vecs[i].e_addr);
      check($sformatf("v%0d fault", i),     32'(fault),     32'(vecs[i].e_fault));
      check($sformatf("v%0d halted", i),    32'(halted),    32'(vecs[i].e_halted));
    end

    // Free-run from head pc 0 to the end of memory: one word per cycle up to 108.
    for (int a = 4; a <= 108; a += 4) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      check($sformatf("run pc%0d out_pc", a),    out_pc,            32'(a));
      check($sformatf("run pc%0d out_instr", a), out_instr,         word_at(32'(a)));
      check($sformatf("run pc%0d valid", a),     32'(out_valid),    32'd1);
      check($sformatf("run pc%0d halted", a),    32'(halted),       32'd0);
    end
    check("run end imem_addr", imem_addr, 32'd112);

    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("halt halted",    32'(halted),    32'd1);
    check("halt out_valid", 32'(out_valid), 32'd0);
    check("halt count",     32'(count),     32'd0);
    check("halt imem_addr", imem_addr,      32'd112);

    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("halt hold halted", 32'(halted), 32'd1);
    check("halt hold count",  32'(count),  32'd0);

    step(1'b0, 1'b1, 32'h0, 1'b1);
    check("resume halted",    32'(halted),    32'd0);
    check("resume count",     32'(count),     32'd0);
    check("resume imem_addr", imem_addr,      32'd0);

    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("resume out_valid", 32'(out_valid), 32'd1);
    check("resume out_pc",    out_pc,         32'd0);
    check("resume out_instr", out_instr,      W0);

    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("resume2 out_pc",    out_pc,    32'd4);
    check("resume2 out_instr", out_instr, W1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC loaded on reset.
REQ-002 Parameter IMEM_BYTES, default 112: byte size of the instruction memory; the last legal fetch address is IMEM_BYTES-4.
REQ-003 Parameter DEPTH, default 2: prefetch buffer entries, a power of two, at least 2.
REQ-004 clk  input  1  clock, all state updates on the rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 imem_addr  output  32  byte address of the word to read, equal to the fetch PC.
REQ-007 imem_rdata  input  32  instruction word at imem_addr, assembled little-endian, valid in the same cycle (combinational memory).
REQ-008 redirect_valid  input  1  branch/jump redirect request.
REQ-009 redirect_pc  input  32  redirect target byte address.
REQ-010 out_valid  output  1  buffer head holds an instruction.
REQ-011 out_ready  input  1  decode accepts the head this cycle.
REQ-012 out_instr  output  32  head instruction word.
REQ-013 out_pc  output  32  byte address of the head instruction.
REQ-014 fault  output  1  high while in FAULT state.
REQ-015 halted  output  1  high while in HALT state.
REQ-016 count  output  $clog2(DEPTH)+1  number of buffered entries.

Function
REQ-017 The block SHALL have three states: RUN, HALT and FAULT.
REQ-018 In RUN, when count<DEPTH or a pop occurs in the same cycle, the block SHALL push {pc, imem_rdata} and advance pc by 4 (32-bit wrap).
REQ-019 A push SHALL NOT occur in HALT or FAULT, or when the buffer is full and no pop occurs.
REQ-020 A pop SHALL occur when out_valid && out_ready; a simultaneous push and pop SHALL leave count unchanged.
REQ-021 out_valid SHALL equal (count!=0); out_instr and out_pc SHALL come from the head entry; entries SHALL leave in fetch order.
REQ-022 Fetch-to-output latency SHALL be 1 cycle: a word pushed at edge N is visible on the outputs after edge N.
REQ-023 In RUN, when pc > IMEM_BYTES-4, the block SHALL push nothing and go to HALT; entries already buffered SHALL still drain.
REQ-024 redirect_valid SHALL have priority over everything else. On a redirect edge:
  - flush the buffer (count becomes 0, any pop that cycle is discarded);
  - pc becomes redirect_pc;
  - nothing is pushed.
REQ-025 The redirect SHALL set the next state:
  - FAULT if redirect_pc[1:0] != 0;
  - otherwise RUN, including exit from HALT or FAULT.
REQ-026 pc[1:0] SHALL always be 0 in RUN.
REQ-027 imem_addr SHALL equal pc in every state.

Reset
REQ-028 While reset is high, at each edge the block SHALL set:
  - pc=RESET_PC, count=0, state=RUN;
  - out_valid=0, fault=0, halted=0;
  - out_instr=0, out_pc=0.
REQ-029 Reset SHALL override redirect_valid and out_ready in the same cycle.
REQ-030 Reset mid-operation SHALL discard all buffered entries.
REQ-031 The first push SHALL occur on the first edge after reset falls.

Verification
REQ-032 Release reset with out_ready=1 and memory words 0x00c28283@0 and 0x800100b3@4.
  - Expected: cycle 1 out_pc=0, out_instr=0x00c28283; cycle 2 out_pc=4, out_instr=0x800100b3; out_valid stays high.
REQ-033 Hold out_ready=0 for 5 cycles after reset.
  - Expected: count rises to 2 and holds; imem_addr holds at 8; out_pc stays 0.
  - Then raise out_ready for one cycle. Expected: head becomes pc 4 and count stays 2.
REQ-034 With 2 entries buffered, assert redirect_valid with redirect_pc=80 and out_ready=1.
  - Expected: next cycle count=0 and out_valid=0; the cycle after, out_pc=80.
REQ-035 Free-run with out_ready=1 and IMEM_BYTES=112.
  - Expected: the last out_pc is 108; halted rises when pc=112; out_valid falls after the drain.
  - Then redirect to 0. Expected: halted falls and fetch resumes at 0.
REQ-036 Redirect with redirect_pc=0x52.
  - Expected: fault=1, count stays 0, imem_addr=0x52.
  - Then redirect to 0x50. Expected: fault=0 and out_pc=0x50 one cycle later.
REQ-037 Assert reset for 1 cycle while 2 entries are buffered and a redirect is pending.
  - Expected: count=0, pc=RESET_PC, and the redirect is ignored.
